// File: rtl/pcpa_pkg.sv
// -----------------------------------------------------------------------------
// pcpa_pkg
// Shared definitions for the pipelined carry-propagate adder.
//   DEFAULT_N / DEFAULT_STAGES : default operand width and pipeline depth
//   LAT                        : latency in cycles of the default configuration
//   stage_ctl_t                : per-stage control record {valid, carry}
//   slice_w()                  : width of one pipeline slice
// -----------------------------------------------------------------------------
package pcpa_pkg;

    localparam int DEFAULT_N      = 32;
    localparam int DEFAULT_STAGES = 4;
    localparam int LAT            = DEFAULT_STAGES;

    // Control bits that travel alongside each beat: whether the stage holds a
    // live beat, and the carry leaving the slice that stage just added.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // Each stage adds an equal share of the operand bits.
    function automatic int slice_w(input int n, input int stages);
        return n / stages;
    endfunction

endpackage

// File: rtl/cpa_slice.sv
// -----------------------------------------------------------------------------
// cpa_slice
// Combinational W-bit carry-lookahead adder: {cout, s} = a + b + cin.
// Carries are formed with a parallel-prefix (Kogge-Stone) tree over the
// bit-level generate/propagate terms, so depth grows with log2(W).
// Ports:
//   a, b  in   W  slice operands
//   cin   in   1  carry into bit 0
//   s     out  W  slice sum
//   cout  out  1  carry out of bit W-1
// -----------------------------------------------------------------------------
module cpa_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic [W-1:0] ng;
    logic [W-1:0] np;
    logic [W:0]   c;

    // Prefix tree: after the last level gg[i]/pp[i] are the group generate
    // and propagate of bits [i:0]. Each level combines a bit with the group
    // d positions below it, doubling the span every time. The carry into
    // bit i+1 is then the group generate, or the group propagate of cin.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gg = g;
        pp = p;
        ng = g;
        np = p;
        for (int d = 1; d < W; d = d * 2) begin
            ng = gg;
            np = pp;
            for (int i = d; i < W; i++) begin
                ng[i] = gg[i] | (pp[i] & gg[i-d]);
                np[i] = pp[i] & pp[i-d];
            end
            gg = ng;
            pp = np;
        end
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = gg[i] | (pp[i] & cin);
        end
        s    = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/pipelined_cpa.sv
// -----------------------------------------------------------------------------
// pipelined_cpa
// Pipelined carry-propagate adder: {out_cout, out_y} = in_a + in_b + in_cin.
// The operands are cut into STAGES slices of N/STAGES bits. Stage k adds slice
// k using the carry registered by stage k-1, so a beat spends exactly STAGES
// cycles in the pipe and one result can leave every cycle.
// Operands travel with the beat so the upper slices reach their stage in step
// (skew), and finished lower sum bits travel with it too so out_y is coherent
// (deskew).
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready depends only on the output
//   in_a, in_b, in_cin    operands and carry in
//   in_sub                subtract select (present only with PCPA_SUB_EN)
//   out_valid / out_ready output handshake
//   out_y, out_cout       sum modulo 2^N and carry out of bit N-1
// Configuration:
//   PCPA_SUB_EN  when defined, adds in_sub; in_sub=1 gives y = a - b and
//                cout = !borrow. When undefined the block only adds.
// -----------------------------------------------------------------------------
module pipelined_cpa
    import pcpa_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
`ifdef PCPA_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_cout
);

    localparam int W = slice_w(N, STAGES);

    if (STAGES < 1 || STAGES > N) begin : g_bad_stages
        $error("pipelined_cpa: STAGES must lie in 1..N");
    end
    if (N % STAGES != 0) begin : g_bad_split
        $error("pipelined_cpa: N must be a multiple of STAGES");
    end

    logic         advance;
    logic         accept;
    logic [N-1:0] b_eff;
    logic         cin_eff;

    stage_ctl_t   ctl_q [STAGES];
    logic [N-1:0] a_q   [STAGES];
    logic [N-1:0] b_q   [STAGES];
    logic [N-1:0] y_q   [STAGES];

    logic [N-1:0] a_in  [STAGES];
    logic [N-1:0] b_in  [STAGES];
    logic [N-1:0] y_in  [STAGES];
    logic [N-1:0] y_nx  [STAGES];
    logic         c_in  [STAGES];
    logic         v_in  [STAGES];
    logic         co    [STAGES];

    logic         unused_last_operands;

    // The whole pipe moves as one: it may step whenever the output register
    // is empty or being drained. Bubbles therefore ride along instead of
    // being squeezed out, which keeps the handshake purely output-driven.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && in_ready;

    // Subtraction is a + ~b + 1, folded into the operands at accept time so
    // the pipe itself never needs to know about it.
`ifdef PCPA_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] s;
        logic         cout_k;
        logic [N-1:0] y_mix;

        if (k == 0) begin : g_first
            assign a_in[k] = in_a;
            assign b_in[k] = b_eff;
            assign c_in[k] = cin_eff;
            assign v_in[k] = accept;
            assign y_in[k] = '0;
        end else begin : g_next
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = ctl_q[k-1].carry;
            assign v_in[k] = ctl_q[k-1].valid;
            assign y_in[k] = y_q[k-1];
        end

        cpa_slice #(.W(W)) u_slice (
            .a    (a_in[k][k*W +: W]),
            .b    (b_in[k][k*W +: W]),
            .cin  (c_in[k]),
            .s    (s),
            .cout (cout_k)
        );

        // The beat's partial sum picks up this stage's slice; every other
        // bit passes through untouched.
        always_comb begin
            y_mix             = y_in[k];
            y_mix[k*W +: W]   = s;
        end

        assign y_nx[k] = y_mix;
        assign co[k]   = cout_k;
    end

    // Stage registers. Reset clears data as well as control so the outputs
    // read zero, never X, while nothing is valid. When the pipe cannot
    // advance every register holds, which keeps out_y/out_cout stable under
    // back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                y_q[k]   <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k].valid <= v_in[k];
                ctl_q[k].carry <= co[k];
                a_q[k]         <= a_in[k];
                b_q[k]         <= b_in[k];
                y_q[k]         <= y_nx[k];
            end
        end
    end

    // The last stage's operand copies have no consumer; synthesis trims them.
    assign unused_last_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign out_valid = ctl_q[STAGES-1].valid;
    assign out_cout  = ctl_q[STAGES-1].carry;
    assign out_y     = y_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_cpa.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cpa
// Directed self-checking bench for pipelined_cpa at N=32, STAGES=4.
// Expected {cout, y} values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipelined_cpa;

    localparam int N      = 32;
    localparam int STAGES = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
`ifdef PCPA_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_y;
    logic         out_cout;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] sa   [8];
    logic [31:0] sb   [8];
    logic        sc   [8];
    logic [32:0] sexp [8];

    pipelined_cpa #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PCPA_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_cout  (out_cout)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operand beat on the input side.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
    endtask

    // Send one beat into an empty pipe, measure its latency and check the result.
    task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic [32:0] expected);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(a, b, cin);
        #1;
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 64'(lat), 64'(STAGES));
        checkOutput({tag, ".sum"}, 64'({out_cout, out_y}), 64'(expected));
        @(posedge clk);
        #1;
        checkOutput({tag, ".drained"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int sent;
        int got;
        int extra;

        sa[0] = 32'h00000001; sb[0] = 32'h00000002; sc[0] = 1'b0; sexp[0] = {1'b0, 32'h00000003};
        sa[1] = 32'h80000000; sb[1] = 32'h80000000; sc[1] = 1'b0; sexp[1] = {1'b1, 32'h00000000};
        sa[2] = 32'h000000FF; sb[2] = 32'h00000001; sc[2] = 1'b0; sexp[2] = {1'b0, 32'h00000100};
        sa[3] = 32'h00FF00FF; sb[3] = 32'h00010001; sc[3] = 1'b1; sexp[3] = {1'b0, 32'h01000101};
        sa[4] = 32'hAAAAAAAA; sb[4] = 32'h55555555; sc[4] = 1'b0; sexp[4] = {1'b0, 32'hFFFFFFFF};
        sa[5] = 32'hAAAAAAAA; sb[5] = 32'h55555555; sc[5] = 1'b1; sexp[5] = {1'b1, 32'h00000000};
        sa[6] = 32'h7FFFFFFF; sb[6] = 32'h00000001; sc[6] = 1'b0; sexp[6] = {1'b0, 32'h80000000};
        sa[7] = 32'hDEADBEEF; sb[7] = 32'h11111111; sc[7] = 1'b0; sexp[7] = {1'b0, 32'hEFBED000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef PCPA_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset.out_y", 64'(out_y), 64'(0));
        checkOutput("reset.out_cout", 64'(out_cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.in_ready", 64'(in_ready), 64'(1));

        // Single beats, including carries that cross every slice boundary.
        runSingle("zero", 32'h00000000, 32'h00000000, 1'b0, {1'b0, 32'h00000000});
        runSingle("ripple_all", 32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000});
        runSingle("not_a_cin", 32'h12345678, 32'hEDCBA987, 1'b1, {1'b1, 32'h00000000});
        runSingle("neg_a", 32'h12345678, 32'hEDCBA988, 1'b0, {1'b1, 32'h00000000});
        runSingle("slice_cross", 32'h0000FFFF, 32'h00000001, 1'b0, {1'b0, 32'h00010000});

        // Back-to-back stream with a three-cycle output stall in the middle.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c < 9);
            if (sent < 8) applyStimulus(sa[sent], sb[sent], sc[sent]);
            else in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                checkOutput("stall.in_ready", 64'(in_ready), 64'(0));
                checkOutput("stall.hold", 64'({out_cout, out_y}), 64'(sexp[got]));
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream[%0d]", got), 64'({out_cout, out_y}), 64'(sexp[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream.sent", 64'(sent), 64'(8));
        checkOutput("stream.got", 64'(got), 64'(8));
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        checkOutput("stream.extra", 64'(extra), 64'(0));

        // Reset with three beats in flight, the oldest sitting at the output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(32'h11111111, 32'h22222222, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midrst.pre_valid", 64'(out_valid), 64'(1));
        checkOutput("midrst.pre_sum", 64'({out_cout, out_y}), 64'({1'b0, 32'h33333333}));
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.out_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst.out_y", 64'(out_y), 64'(0));
        checkOutput("midrst.out_cout", 64'(out_cout), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst.in_ready", 64'(in_ready), 64'(1));
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        checkOutput("midrst.emerged", 64'(extra), 64'(0));

`ifdef PCPA_SUB_EN
        // Subtraction: in_cin is ignored while in_sub is set.
        in_sub = 1'b1;
        runSingle("sub_5_7", 32'h00000005, 32'h00000007, 1'b0, {1'b0, 32'hFFFFFFFE});
        runSingle("sub_7_5", 32'h00000007, 32'h00000005, 1'b0, {1'b1, 32'h00000002});
        in_sub = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
